// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider: 50% duty f_out = f_clk / (2*cur_div) plus a tick on each
// rising edge of f_out. New divisors take effect only at the end of a full period.
module clk_divider_prog #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             f_out,
  output logic             tick,
  output logic             div_busy,
  output logic             load_err,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [CNT_W-1:0] ResetDiv = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             f_out_q, f_out_d;
  logic             tick_q, tick_d;
  logic             load_err_q, load_err_d;

  logic load_ok;
  logic terminal;

  assign load_ok  = div_load && (div_val != '0);
  assign terminal = (cnt_q == cur_div_q - CNT_W'(1));

  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    f_out_d    = f_out_q;
    tick_d     = 1'b0;
    load_err_d = div_load && (div_val == '0);

    if (en) begin
      if (terminal) begin
        cnt_d   = '0;
        f_out_d = ~f_out_q;
        tick_d  = ~f_out_q;
        // Falling edge closes a full period: the only safe point to switch divisors.
        if (f_out_q && busy_q) begin
          cur_div_d = pend_q;
          busy_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Applied after the swap so a coincident load queues behind the one just applied.
      if (load_ok) begin
        pend_d = div_val;
        busy_d = 1'b1;
      end
    end else begin
      cnt_d   = '0;
      f_out_d = 1'b0;
      if (busy_q) begin
        cur_div_d = pend_q;
        busy_d    = 1'b0;
      end
      // Stopped: no phase in progress, so a new divisor is taken at once.
      if (load_ok) begin
        pend_d    = div_val;
        cur_div_d = div_val;
        busy_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      cur_div_q  <= ResetDiv;
      pend_q     <= '0;
      busy_q     <= 1'b0;
      f_out_q    <= 1'b0;
      tick_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      f_out_q    <= f_out_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
    end
  end

  assign f_out    = f_out_q;
  assign tick     = tick_q;
  assign div_busy = busy_q;
  assign load_err = load_err_q;
  assign cur_div  = cur_div_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog (CNT_W=8, DEFAULT_DIV=3): directed stimulus pushes expected tick
// records (spacing and divisor in use); a monitor pops one per observed tick.
module tb_clk_divider_prog;

  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [CntW-1:0] div_val;
  logic            div_load;
  logic            f_out;
  logic            tick;
  logic            div_busy;
  logic            load_err;
  logic [CntW-1:0] cur_div;

  typedef struct {
    int gap;
    int div;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ref_cyc = 0;

  always #5 clk = ~clk;

  clk_divider_prog #(
    .CNT_W      (CntW),
    .DEFAULT_DIV(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .f_out   (f_out),
    .tick    (tick),
    .div_busy(div_busy),
    .load_err(load_err),
    .cur_div (cur_div)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int gap, input int div);
    exp_t e;
    e.gap = gap;
    e.div = div;
    sb_q.push_back(e);
  endtask

  // Monitor: rise spacing is measured from the previous tick or the last stopped/reset edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst || !en) begin
        ref_cyc = cyc;
      end else if (tick) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_tick: got tick at cycle %0d, expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("sb_tick_gap", 32'(cyc - ref_cyc), 32'(e.gap));
          chk("sb_tick_div", 32'(cur_div), 32'(e.div));
          chk("sb_tick_fout", 32'(f_out), 32'd1);
        end
        ref_cyc = cyc;
      end
    end
  end

  initial begin
    rst      = 1'b0;
    en       = 1'b0;
    div_val  = '0;
    div_load = 1'b0;
    step(2);
    chk("rst_fout", 32'(f_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_lerr", 32'(load_err), 32'd0);
    chk("rst_div", 32'(cur_div), 32'd3);

    // Basic run, load 5 mid-high, reject 0, last-wins 4->7, stop/resume, div 1 and 255.
    push(3, 3); push(6, 3); push(8, 5); push(10, 5); push(12, 7); push(7, 7);
    push(8, 1); push(2, 1); push(2, 1); push(2, 1); push(256, 255);
    rst = 1'b1;
    en  = 1'b1;
    step(3);
    chk("first_rise", 32'(f_out), 32'd1);
    step(6);
    chk("second_tick", 32'(tick), 32'd1);
    div_val  = 8'd5;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("load5_busy", 32'(div_busy), 32'd1);
    chk("load5_div_old", 32'(cur_div), 32'd3);
    step(2);
    chk("apply5_div", 32'(cur_div), 32'd5);
    chk("apply5_busy", 32'(div_busy), 32'd0);
    chk("apply5_fout", 32'(f_out), 32'd0);
    step(15);
    chk("div5_tick", 32'(tick), 32'd1);
    div_val  = 8'd0;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("load0_err", 32'(load_err), 32'd1);
    chk("load0_busy", 32'(div_busy), 32'd0);
    chk("load0_div", 32'(cur_div), 32'd5);
    step(1);
    chk("load0_err_clr", 32'(load_err), 32'd0);
    div_val  = 8'd4;
    div_load = 1'b1;
    step(1);
    div_val = 8'd7;
    step(1);
    div_load = 1'b0;
    chk("load47_busy", 32'(div_busy), 32'd1);
    chk("load47_div_old", 32'(cur_div), 32'd5);
    step(1);
    chk("apply7_div", 32'(cur_div), 32'd7);
    chk("apply7_busy", 32'(div_busy), 32'd0);
    step(7);
    chk("div7_rise", 32'(f_out), 32'd1);
    en = 1'b0;
    step(1);
    chk("stop_fout", 32'(f_out), 32'd0);
    chk("stop_tick", 32'(tick), 32'd0);
    step(2);
    en = 1'b1;
    step(7);
    chk("resume_rise", 32'(f_out), 32'd1);
    div_val  = 8'd1;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    step(7);
    chk("div1_applied", 32'(cur_div), 32'd1);
    chk("div1_rise", 32'(f_out), 32'd1);
    step(4);
    chk("div1_toggle", 32'(f_out), 32'd1);
    div_val  = 8'd255;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("load255_busy", 32'(div_busy), 32'd1);
    chk("div1_fall", 32'(f_out), 32'd0);
    step(2);
    chk("apply255_div", 32'(cur_div), 32'd255);
    chk("apply255_busy", 32'(div_busy), 32'd0);
    step(255);
    chk("div255_rise", 32'(tick), 32'd1);
    step(254);
    chk("div255_high_end", 32'(f_out), 32'd1);
    step(1);
    chk("div255_fall", 32'(f_out), 32'd0);

    // Async reset mid-period while a load is pending.
    div_val  = 8'd9;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("load9_busy", 32'(div_busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_fout", 32'(f_out), 32'd0);
    chk("arst_busy", 32'(div_busy), 32'd0);
    chk("arst_div", 32'(cur_div), 32'd3);
    chk("arst_tick", 32'(tick), 32'd0);
    step(2);

    // Coincident load/apply, then apply-on-stop and load-while-stopped.
    push(3, 3); push(5, 2); push(6, 4); push(5, 5);
    rst = 1'b1;
    step(3);
    chk("rst2_rise_div", 32'(cur_div), 32'd3);
    div_val  = 8'd2;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("load2_busy", 32'(div_busy), 32'd1);
    step(1);
    div_val  = 8'd4;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("coinc_div", 32'(cur_div), 32'd2);
    chk("coinc_busy", 32'(div_busy), 32'd1);
    chk("coinc_fout", 32'(f_out), 32'd0);
    step(2);
    chk("div2_rise", 32'(tick), 32'd1);
    step(2);
    chk("apply4_div", 32'(cur_div), 32'd4);
    chk("apply4_busy", 32'(div_busy), 32'd0);
    step(4);
    chk("div4_rise", 32'(tick), 32'd1);
    div_val  = 8'd6;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    en       = 1'b0;
    step(1);
    chk("stop_apply_div", 32'(cur_div), 32'd6);
    chk("stop_apply_busy", 32'(div_busy), 32'd0);
    chk("stop_apply_fout", 32'(f_out), 32'd0);
    div_val  = 8'd5;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("stopped_load_div", 32'(cur_div), 32'd5);
    chk("stopped_load_busy", 32'(div_busy), 32'd0);
    en = 1'b1;
    step(5);
    chk("div5_resume_rise", 32'(f_out), 32'd1);
    step(5);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
